// File: rtl/reg_write_arbiter_pkg.sv
// Shared defaults for the register-write arbiter and its datapath users,
// plus the round-robin pointer advance helper.
package reg_write_arbiter_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_N_REGS = 8;
  localparam int DEF_AW     = 3;
  localparam int DEF_N_REQ  = 4;
  localparam int DEF_IDW    = 2;

  // Next pointer after serving requester w: one past the winner, wrapping.
  function automatic int rr_next(input int w, input int n);
    return (w == n - 1) ? 0 : w + 1;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_grant.sv
// Combinational round-robin pick: first eligible index scanning from ptr
// upward with wrap-around.
module rr_grant #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] eligible_i,
  input  logic [IDW-1:0]   ptr_i,
  output logic [IDW-1:0]   win_id_o,
  output logic             win_vld_o
);

  always_comb begin
    int idx;
    win_id_o  = '0;
    win_vld_o = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_i) + k) % N_REQ;
      if (!win_vld_o && eligible_i[idx]) begin
        win_vld_o = 1'b1;
        win_id_o  = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the single write port of a register bank,
// with a one-cycle ack per committed write and a combinational read port.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int N_REGS = DEF_N_REGS,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int AW     = DEF_AW,
  parameter int IDW    = DEF_IDW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*AW-1:0]    wr_addr,
  input  logic [N_REQ*WIDTH-1:0] wr_data,
  output logic [N_REQ-1:0]       ack,
  output logic                   grant_valid,
  output logic [IDW-1:0]         grant_id,
  input  logic [AW-1:0]          rd_addr,
  output logic [WIDTH-1:0]       rd_data
);

  localparam int           BIW  = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam logic [AW:0]  NR_L = (AW+1)'(N_REGS);

  logic [WIDTH-1:0] bank_q [N_REGS];
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             gv_q, gv_d;
  logic [IDW-1:0]   gid_q, gid_d;
  logic [IDW-1:0]   ptr_q, ptr_d;

  logic [N_REQ-1:0] eligible;
  logic [IDW-1:0]   win_id;
  logic             win_vld;
  logic [AW-1:0]    win_addr;
  logic [WIDTH-1:0] win_data;
  logic             wr_en;

  // A requester still holding req during its ack cycle must not write twice.
  assign eligible = req & ~ack_q;

  rr_grant #(.N_REQ(N_REQ), .IDW(IDW)) u_rr_grant (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .win_id_o   (win_id),
    .win_vld_o  (win_vld)
  );

  always_comb begin
    win_addr = wr_addr[int'(win_id)*AW +: AW];
    win_data = wr_data[int'(win_id)*WIDTH +: WIDTH];
    // Out-of-range writes are still acked, just not committed.
    wr_en    = win_vld && ({1'b0, win_addr} < NR_L);
    ack_d    = '0;
    if (win_vld) ack_d[win_id] = 1'b1;
    gv_d     = win_vld;
    gid_d    = win_vld ? win_id : gid_q;
    ptr_d    = win_vld ? IDW'(rr_next(int'(win_id), N_REQ)) : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < N_REGS; r++) bank_q[r] <= '0;
      ack_q <= '0;
      gv_q  <= 1'b0;
      gid_q <= '0;
      ptr_q <= '0;
    end else begin
      if (wr_en) bank_q[win_addr[BIW-1:0]] <= win_data;
      ack_q <= ack_d;
      gv_q  <= gv_d;
      gid_q <= gid_d;
      ptr_q <= ptr_d;
    end
  end

  assign ack         = ack_q;
  assign grant_valid = gv_q;
  assign grant_id    = gid_q;
  assign rd_data     = ({1'b0, rd_addr} < NR_L) ? bank_q[rd_addr[BIW-1:0]] : '0;

endmodule
